fifo_dpram: RTL and testbench
=============================

Name: fifo_dpram

Overview:
- Parametrised synchronous FIFO: generalised dual-port RAM plus read/write pointer control, occupancy count, status flags and error reporting.
- Serves as the generic buffering element of the TLP FIFO path, between a producer and a consumer stage on the same clock.
- Adds configurable width and depth, full/empty protection, programmable almost-full/almost-empty levels and sticky error flags.

Parameters:
- DATA_W, 4, word width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W words.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request.
- data_in  in  DATA_W  push data.
- rd_en  in  1  pop request.
- err_clr  in  1  synchronous clear of the sticky error flags.
- data_out  out  DATA_W  registered pop data.
- valid_out  out  1  data_out updated this cycle (by an accepted pop).
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky: push attempted while full.
- underflow  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset_L low, asynchronous, any cycle, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, data_out=0, valid_out=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0. RAM contents are not reset and are undefined after reset.
- Flags are decoded from the registered count only; no combinational path from wr_en or rd_en to any flag.
- Push accepted = wr_en & !full, where full is the value at the start of the cycle. An accepted push writes ram[wr_ptr] <= data_in and sets wr_ptr <= wr_ptr+1.
- Pop accepted = rd_en & !empty, where empty is the value at the start of the cycle. An accepted pop sets data_out <= ram[rd_ptr], rd_ptr <= rd_ptr+1, and valid_out <= 1 for exactly the next cycle.
- Pop latency: data appears one clock after the accepted rd_en. Without an accepted pop, valid_out=0 and data_out holds its last value.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on a push-only cycle.
  - -1 on a pop-only cycle.
  - Unchanged when both are accepted or neither is.
- Simultaneous push and pop:
  - When 0<count<DEPTH, both are accepted.
  - When empty, only the push is accepted; no fall-through, so the new word is not readable in the same cycle. underflow sets.
  - When full, only the pop is accepted; the push is dropped and overflow sets.
- Same-address read/write: a pop never reads a slot being written in the same cycle, because this only arises when empty, and then the pop is rejected.
- Errors:
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
  - Both are sticky until err_clr=1 (next edge) or reset.
  - If err_clr and a new error event occur in the same cycle, the set wins.
- Rejected requests change no pointer, count or RAM location.

Test Plan:
- Reset values: hold reset_L=0 for 3 cycles, then release → count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0, valid_out=0, overflow=0, underflow=0. Assert reset_L mid-fill at count=5 → all of these return to reset values immediately, without waiting for a clock edge.
- Fill to full: push 0x1..0x8 on 8 consecutive cycles →
  - almost_full rises when count=6;
  - almost_empty falls when count=3;
  - full=1 when count=8.
  A 9th push of 0xF → overflow=1, count stays 8, and the word is dropped.
- Drain: pop 8 times → data_out sequence 0x1..0x8, each one cycle after its rd_en, with valid_out high on each. Then empty=1. A 9th pop → underflow=1, valid_out=0, and data_out holds 0x8.
- Wrap-around: run 20 cycles of interleaved push/pop keeping count between 1 and 3 → all words emerge in order with none lost, across at least two pointer wraps.
- Simultaneous operations:
  - With count=4 and push+pop in the same cycle → count stays 4 and the oldest word is output.
  - With empty and push+pop → count=1, valid_out=0, underflow=1.
  - With full and push+pop → count=7, overflow=1, oldest word output.
- Error clear: set overflow, then pulse err_clr → overflow=0 next cycle. Repeat with err_clr and wr_en&full in the same cycle → overflow stays 1.

Source files
------------

// File: rtl/fifo_dpram.sv
`default_nettype none
// ============================================================================
// Module  : fifo_dpram
// Brief   : Synchronous FIFO built on a dual-port RAM with occupancy count,
//           programmable almost-full/almost-empty flags and sticky errors.
// Rev     : 1.0 - initial release
// ============================================================================
module fifo_dpram #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Flags decode only the registered count, so requests never reach them.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign push_ok = wr_en & ~full;
    assign pop_ok  = rd_en & ~empty;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error event takes priority over a clear in the same cycle.
            if (wr_en & full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en & empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_dpram.sv
`default_nettype none
// Testbench for fifo_dpram: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_fifo_dpram;

    localparam int DATA_W = 4;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 2;

    logic              clk = 1'b0;
    logic              reset_L = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              rd_en = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;

    fifo_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},     32'(count),        32'(n));
        chk({tag, ".empty"},     32'(empty),        32'(n == 0));
        chk({tag, ".full"},      32'(full),         32'(n == DEPTH));
        chk({tag, ".afull"},     32'(almost_full),  32'(n >= AF));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(n <= AE));
        chk({tag, ".valid"},     32'(valid_out),    32'(m_valid));
        chk({tag, ".data_out"},  32'(data_out),     32'(m_dout));
        chk({tag, ".overflow"},  32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"}, 32'(underflow),    32'(m_unf));
    endtask

    // One clock: model evaluates the rules on pre-edge state, then outputs are compared.
    task automatic cycle(input string tag);
        bit was_full, was_empty;
        @(posedge clk);
        if (!reset_L) begin
            model_reset();
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            m_valid = 1'b0;
            if (rd_en && !was_empty) begin
                m_dout  = q.pop_front();
                m_valid = 1'b1;
            end
            if (wr_en && !was_full) q.push_back(data_in);
            if (wr_en && was_full) m_ovf = 1'b1;
            else if (err_clr)      m_ovf = 1'b0;
            if (rd_en && was_empty) m_unf = 1'b1;
            else if (err_clr)       m_unf = 1'b0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit w, input bit r, input bit c, input logic [DATA_W-1:0] d);
        wr_en   = w;
        rd_en   = r;
        err_clr = c;
        data_in = d;
    endtask

    initial begin
        // Reset held for 3 cycles
        drive(0, 0, 0, '0);
        reset_L = 1'b0;
        model_reset();
        repeat (3) cycle("rst");
        reset_L = 1'b1;
        check_all("rst_rel");

        // Fill 1..8, then a 9th push that must be dropped
        for (int i = 1; i <= 8; i++) begin
            drive(1, 0, 0, 4'(i));
            cycle("fill");
        end
        drive(1, 0, 0, 4'hF);
        cycle("fill_ovf");

        // Drain 8, then a 9th pop on empty
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, '0);
            cycle("drain");
        end
        chk("drain_last", 32'(data_out), 32'h8);
        drive(0, 1, 0, '0);
        cycle("drain_unf");

        // Clear both sticky flags
        drive(0, 0, 1, '0);
        cycle("errclr");

        // Wrap-around: keep count within 1..3
        drive(1, 0, 0, 4'(($urandom % 16)));
        cycle("wrap_pre");
        for (int i = 0; i < 20; i++) begin
            if (q.size() <= 1)      drive(1, $urandom_range(0, 1) == 1, 0, 4'($urandom % 16));
            else if (q.size() >= 3) drive($urandom_range(0, 1) == 1, 1, 0, 4'($urandom % 16));
            else                    drive(1, 1, 0, 4'($urandom % 16));
            cycle("wrap");
        end

        // Bring to count 4, then push+pop together
        while (q.size() < 4) begin
            drive(1, 0, 0, 4'($urandom % 16));
            cycle("to4");
        end
        drive(1, 1, 0, 4'hA);
        cycle("sim_mid");

        // Empty, then push+pop together
        while (q.size() > 0) begin
            drive(0, 1, 0, '0);
            cycle("to0");
        end
        drive(1, 1, 0, 4'h5);
        cycle("sim_empty");

        // Full, then push+pop together
        while (q.size() < DEPTH) begin
            drive(1, 0, 0, 4'($urandom % 16));
            cycle("to8");
        end
        drive(1, 1, 0, 4'hC);
        cycle("sim_full");

        // Clear colliding with a fresh overflow: set wins
        drive(1, 0, 0, 4'h3);
        cycle("refill");
        drive(0, 0, 1, '0);
        cycle("clr1");
        drive(1, 0, 1, 4'h7);
        cycle("clr_vs_set");

        // Mid-fill asynchronous reset at count 5
        while (q.size() > 0) begin
            drive(0, 1, 0, '0);
            cycle("to0b");
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 4'(i + 2));
            cycle("midfill");
        end
        drive(0, 0, 0, '0);
        reset_L = 1'b0;
        model_reset();
        #2;
        check_all("async_rst");
        cycle("async_hold");
        reset_L = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  $urandom_range(0, 99) < 5, 4'($urandom % 16));
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
